// File: rtl/router_pkg.sv
// Shared router sizing, index types and small helpers used by the
// per-port allocators.
package router_pkg;
    localparam int NUM_VC    = 4;
    localparam int NUM_PORTS = 4;
    localparam int NUM_REQ   = NUM_PORTS * NUM_VC;
    localparam int REQ_BITS  = $clog2(NUM_REQ);
    localparam int VC_BITS   = $clog2(NUM_VC);
    localparam int PORT_BITS = $clog2(NUM_PORTS);

    typedef logic [VC_BITS-1:0]   vc_idx_t;
    typedef logic [PORT_BITS-1:0] port_idx_t;
    typedef logic [REQ_BITS-1:0]  req_idx_t;

    // Round-robin pointer advance: one past the winner, wrapping to 0.
    function automatic req_idx_t next_ptr(input req_idx_t winner);
        if (winner == req_idx_t'(NUM_REQ - 1))
            return '0;
        return winner + req_idx_t'(1);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit at or
// above ptr, searching circularly. Also used by the switch allocator.
module rr_arbiter #(
    parameter int N        = 16,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [IDX_BITS-1:0] grant_idx
);
    // Circular priority search starting at ptr.
    always_comb begin
        int  k;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        for (int i = 0; i < N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found     = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = IDX_BITS'(k);
            end
        end
    end
endmodule

// File: rtl/output_vc_allocator.sv
// Per-output-port VC allocator: one round-robin grant per cycle, lowest
// free output VC, busy tracking until the tail flit releases the VC.
module output_vc_allocator
    import router_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                release_valid,
    input  logic [VC_BITS-1:0]  release_vc,
    output logic                grant_valid,
    output logic [REQ_BITS-1:0] grant_req,
    output logic [VC_BITS-1:0]  grant_vc,
    output logic [NUM_VC-1:0]   vc_busy,
    output logic                release_error
);
    req_idx_t           ptr;
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_grant;
    req_idx_t           winner;
    logic               arb_any;
    vc_idx_t            free_vc;
    logic               free_any;
    logic               do_grant;
    logic               rel_hit;
    logic               rel_err;
    logic [NUM_VC-1:0]  busy_next;

    // Mask the requester whose grant is on the outputs right now; it still
    // holds req this cycle and must not be granted twice.
    always_comb begin
        mask = '0;
        if (grant_valid)
            mask[grant_req] = 1'b1;
        eligible = req & ~mask;
    end

    rr_arbiter #(
        .N        (NUM_REQ),
        .IDX_BITS (REQ_BITS)
    ) u_arb (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (winner)
    );

    assign arb_any = |arb_grant;

    // Lowest-index free VC, judged before any same-cycle release.
    always_comb begin
        free_vc  = '0;
        free_any = 1'b0;
        for (int v = NUM_VC - 1; v >= 0; v--) begin
            if (!vc_busy[v]) begin
                free_any = 1'b1;
                free_vc  = vc_idx_t'(v);
            end
        end
    end

    // Next busy vector: release clears, grant sets. They never target the
    // same VC since the granted VC was free and the released one busy.
    always_comb begin
        rel_hit   = release_valid &&  vc_busy[release_vc];
        rel_err   = release_valid && !vc_busy[release_vc];
        do_grant  = arb_any && free_any;
        busy_next = vc_busy;
        if (rel_hit)
            busy_next[release_vc] = 1'b0;
        if (do_grant)
            busy_next[free_vc] = 1'b1;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            grant_valid   <= 1'b0;
            grant_req     <= '0;
            grant_vc      <= '0;
            vc_busy       <= '0;
            release_error <= 1'b0;
            ptr           <= '0;
        end else begin
            vc_busy       <= busy_next;
            release_error <= rel_err;
            grant_valid   <= do_grant;
            if (do_grant) begin
                grant_req <= winner;
                grant_vc  <= free_vc;
                ptr       <= next_ptr(winner);
            end
        end
    end
endmodule

// File: tb/tb_output_vc_allocator.sv
// Bench for output_vc_allocator: a behavioural model predicts each cycle's
// outputs into a queue at drive time; entries are popped after the edge.
module tb_output_vc_allocator;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        release_valid;
    logic [1:0]  release_vc;
    logic        grant_valid;
    logic [3:0]  grant_req;
    logic [1:0]  grant_vc;
    logic [3:0]  vc_busy;
    logic        release_error;

    output_vc_allocator dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .release_valid (release_valid),
        .release_vc    (release_vc),
        .grant_valid   (grant_valid),
        .grant_req     (grant_req),
        .grant_vc      (grant_vc),
        .vc_busy       (vc_busy),
        .release_error (release_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       gv;
        logic [3:0] greq;
        logic [1:0] gvc;
        logic [3:0] busy;
        logic       rerr;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // model state
    logic       m_gv = 0;
    logic [3:0] m_greq = 0;
    logic [1:0] m_gvc = 0;
    logic [3:0] m_busy = 0;
    logic       m_rerr = 0;
    int         m_ptr = 0;

    // requester behaviour: held requests, drop one cycle after seeing grant
    logic [15:0] held = 0;
    logic [15:0] drop_pending = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] elig;
        int          win;
        int          fv;
        logic [3:0]  nb;
        elig = req;
        if (m_gv) elig[m_greq] = 1'b0;
        if (!reset) begin
            m_gv = 0; m_greq = 0; m_gvc = 0; m_busy = 0; m_rerr = 0; m_ptr = 0;
            return;
        end
        win = -1;
        for (int n = 0; n < 16 && win < 0; n++)
            if (elig[(m_ptr + n) % 16]) win = (m_ptr + n) % 16;
        fv = -1;
        for (int v = 0; v < 4 && fv < 0; v++)
            if (!m_busy[v]) fv = v;
        nb = m_busy;
        m_rerr = 0;
        if (release_valid) begin
            if (m_busy[release_vc]) nb[release_vc] = 1'b0;
            else m_rerr = 1;
        end
        if (win >= 0 && fv >= 0) begin
            nb[fv] = 1'b1;
            m_gv   = 1;
            m_greq = 4'(win);
            m_gvc  = 2'(fv);
            m_ptr  = (win + 1) % 16;
        end else begin
            m_gv = 0;
        end
        m_busy = nb;
    endtask

    // one clock: drive, predict, clock, compare, update requesters
    task automatic step(input logic rst, input logic rv, input logic [1:0] rvc);
        exp_t e;
        reset = rst;
        req = held;
        release_valid = rv;
        release_vc = rvc;
        model_step();
        q.push_back('{m_gv, m_greq, m_gvc, m_busy, m_rerr});
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("grant_valid", 32'(grant_valid), 32'(e.gv));
        chk("grant_req", 32'(grant_req), 32'(e.greq));
        chk("grant_vc", 32'(grant_vc), 32'(e.gvc));
        chk("vc_busy", 32'(vc_busy), 32'(e.busy));
        chk("release_error", 32'(release_error), 32'(e.rerr));
        held = held & ~drop_pending;
        drop_pending = 0;
        if (grant_valid) drop_pending[grant_req] = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0);
    endtask

    initial begin
        reset = 0; req = 0; release_valid = 0; release_vc = 0;

        // reset hold with all requests asserted
        held = 16'hFFFF;
        step(1'b0, 1'b0, 2'd0);
        step(1'b0, 1'b0, 2'd0);
        chk("rst_gv", 32'(grant_valid), 0);
        chk("rst_busy", 32'(vc_busy), 0);
        chk("rst_rerr", 32'(release_error), 0);
        held = 0; drop_pending = 0;

        // single request
        held = 16'h0020;
        step(1'b1, 1'b0, 2'd0);
        chk("single_gv", 32'(grant_valid), 1);
        chk("single_req", 32'(grant_req), 5);
        chk("single_vc", 32'(grant_vc), 0);
        chk("single_busy", 32'(vc_busy), 4'b0001);
        step(1'b1, 1'b0, 2'd0);
        chk("single_regrant", 32'(grant_valid), 0);
        idle(1);

        // reset to clear allocation and pointer, then round-robin
        step(1'b0, 1'b0, 2'd0);
        chk("midrst_busy", 32'(vc_busy), 0);
        held = 16'h4204;
        step(1'b1, 1'b0, 2'd0);
        chk("rr_req0", 32'(grant_req), 2);
        chk("rr_vc0", 32'(grant_vc), 0);
        step(1'b1, 1'b0, 2'd0);
        chk("rr_req1", 32'(grant_req), 9);
        chk("rr_vc1", 32'(grant_vc), 1);
        step(1'b1, 1'b0, 2'd0);
        chk("rr_gv2", 32'(grant_valid), 1);
        chk("rr_req2", 32'(grant_req), 14);
        chk("rr_vc2", 32'(grant_vc), 2);
        chk("rr_busy", 32'(vc_busy), 4'b0111);
        idle(2);

        // wrap-around: pointer sits at 15
        step(1'b1, 1'b1, 2'd0);
        step(1'b1, 1'b1, 2'd1);
        chk("wrap_busy_pre", 32'(vc_busy), 4'b0100);
        held = 16'h8001;
        step(1'b1, 1'b0, 2'd0);
        chk("wrap_req0", 32'(grant_req), 15);
        chk("wrap_vc0", 32'(grant_vc), 0);
        step(1'b1, 1'b0, 2'd0);
        chk("wrap_req1", 32'(grant_req), 0);
        chk("wrap_vc1", 32'(grant_vc), 1);
        idle(2);

        // exhaustion: fill vc3, then hold req[3]
        held = 16'h0080;
        step(1'b1, 1'b0, 2'd0);
        chk("exh_fill_vc", 32'(grant_vc), 3);
        idle(2);
        chk("exh_busy", 32'(vc_busy), 4'b1111);
        held = 16'h0008;
        idle(2);
        chk("exh_wait", 32'(grant_valid), 0);
        step(1'b1, 1'b1, 2'd2);
        chk("exh_rel_same", 32'(grant_valid), 0);
        step(1'b1, 1'b0, 2'd0);
        chk("exh_gv", 32'(grant_valid), 1);
        chk("exh_req", 32'(grant_req), 3);
        chk("exh_vc", 32'(grant_vc), 2);
        idle(2);

        // bad release
        step(1'b0, 1'b0, 2'd0);
        held = 16'h0001;
        step(1'b1, 1'b0, 2'd0);
        idle(2);
        step(1'b1, 1'b1, 2'd3);
        chk("bad_rel_err", 32'(release_error), 1);
        chk("bad_rel_busy", 32'(vc_busy), 4'b0001);
        step(1'b1, 1'b0, 2'd0);
        chk("bad_rel_pulse", 32'(release_error), 0);

        // random traffic against the model, with an occasional reset
        for (int c = 0; c < 400; c++) begin
            logic       rv;
            logic [1:0] rvc;
            logic       rst;
            if ($urandom_range(0, 3) == 0)
                held = held | 16'(1 << $urandom_range(0, 15));
            rv  = ($urandom_range(0, 2) == 0);
            rvc = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) != 0);
            if (!rst) begin
                held = 0;
                drop_pending = 0;
            end
            step(rst, rv, rvc);
        end

        chk("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
